// File: rtl/mem_access_unit.sv
// Load/store controller in front of the 16-bit data memory: halfword access, range/alignment checks.
// Define MAU_BYTE_ACCESS_EN to build byte loads (sign/zero extend) and byte stores via read-modify-write.
module mem_access_unit #(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_byte_i,
  input  logic        req_signed_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [15:0] mem_raddr_o,
  output logic [15:0] mem_waddr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
`ifdef MAU_BYTE_ACCESS_EN
    RMW_RD,
    RMW_WR,
`endif
    RESP
  } state_e;

  localparam logic [15:0] MemWordsL = 16'(MEM_WORDS);

  state_e      state_q, state_d;
  logic [14:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [15:0] mwdata_q, mwdata_d, rdata_q, rdata_d;
  logic        err_q, err_d, reqErr;
`ifdef MAU_BYTE_ACCESS_EN
  logic        lane_q, lane_d, byte_q, byte_d, signed_q, signed_d;
  logic [7:0]  bdata_q, bdata_d, loadLane;

  assign loadLane = lane_q ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
`else
  logic        unusedSigned;

  assign unusedSigned = req_signed_i;
`endif

  always_comb begin
    reqErr = ({1'b0, req_addr_i[15:1]} >= MemWordsL);
`ifdef MAU_BYTE_ACCESS_EN
    if (!req_byte_i && req_addr_i[0]) reqErr = 1'b1;
`else
    if (req_byte_i || req_addr_i[0]) reqErr = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      raddr_q  <= '0;
      waddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef MAU_BYTE_ACCESS_EN
      lane_q   <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      bdata_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef MAU_BYTE_ACCESS_EN
      lane_q   <= lane_d;
      byte_q   <= byte_d;
      signed_q <= signed_d;
      bdata_q  <= bdata_d;
`endif
    end
  end

  // Memory addresses and write data only move when a real access is scheduled, so they hold otherwise.
  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef MAU_BYTE_ACCESS_EN
    lane_d   = lane_q;
    byte_d   = byte_q;
    signed_d = signed_q;
    bdata_d  = bdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          rdata_d  = '0;
          err_d    = reqErr;
`ifdef MAU_BYTE_ACCESS_EN
          lane_d   = req_addr_i[0];
          byte_d   = req_byte_i;
          signed_d = req_signed_i;
`endif
          if (reqErr) begin
            state_d = RESP;
          end else if (!req_write_i) begin
            state_d = LOAD;
            raddr_d = req_addr_i[15:1];
          end else begin
            waddr_d = req_addr_i[15:1];
`ifdef MAU_BYTE_ACCESS_EN
            if (req_byte_i) begin
              state_d = RMW_RD;
              raddr_d = req_addr_i[15:1];
              bdata_d = req_wdata_i[7:0];
            end else begin
              state_d  = STORE;
              mwdata_d = req_wdata_i;
            end
`else
            state_d  = STORE;
            mwdata_d = req_wdata_i;
`endif
          end
        end
      end
      LOAD: begin
`ifdef MAU_BYTE_ACCESS_EN
        rdata_d = byte_q ? {{8{signed_q & loadLane[7]}}, loadLane} : mem_rdata_i;
`else
        rdata_d = mem_rdata_i;
`endif
        state_d = RESP;
      end
      STORE: state_d = RESP;
`ifdef MAU_BYTE_ACCESS_EN
      RMW_RD: begin
        mwdata_d = lane_q ? {bdata_q, mem_rdata_i[7:0]} : {mem_rdata_i[15:8], bdata_q};
        state_d  = RMW_WR;
      end
      RMW_WR: state_d = RESP;
`endif
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read_o  = (state_q == LOAD);
    mem_write_o = (state_q == STORE);
`ifdef MAU_BYTE_ACCESS_EN
    if (state_q == RMW_RD) mem_read_o = 1'b1;
    if (state_q == RMW_WR) mem_write_o = 1'b1;
`endif
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_raddr_o = {raddr_q, 1'b0};
  assign mem_waddr_o = {waddr_q, 1'b0};
  assign mem_wdata_o = mwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random requests against a word-array reference model.
// Byte-access expectations follow MAU_BYTE_ACCESS_EN, matching the build under test.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqWrite, reqByte, reqSigned;
  logic [15:0] reqAddr, reqWdata;
  logic        rspValid, rspErr;
  logic [15:0] rspRdata;
  logic        memRead, memWrite;
  logic [15:0] memRaddr, memWaddr, memWdata, memRdata;

  logic [15:0] mem       [0:127];
  logic [15:0] initImage [0:127];
  logic [15:0] refMem    [0:127];
  logic        preload;

  int          assertCount = 0;
  int          failCount = 0;
  int          readCount = 0;
  int          writeCount = 0;
  logic [15:0] lastWaddr = '0;
  logic [15:0] lastWdata = '0;
  logic [15:0] lastRdata;
  logic        lastErr;
  int          lastLat;

  mem_access_unit #(.MEM_WORDS(100)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_write_i(reqWrite),
    .req_byte_i(reqByte), .req_signed_i(reqSigned), .req_addr_i(reqAddr),
    .req_wdata_i(reqWdata), .rsp_valid_o(rspValid), .rsp_rdata_o(rspRdata),
    .rsp_err_o(rspErr), .mem_read_o(memRead), .mem_write_o(memWrite),
    .mem_raddr_o(memRaddr), .mem_waddr_o(memWaddr), .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  // Data memory: 100 words, writes land on the rising edge ending a mem_write cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= initImage[i];
    end else if (memWrite && memWaddr[15:1] < 15'd100) begin
      mem[memWaddr[7:1]] <= memWdata;
    end
  end

  always_comb memRdata = (memRaddr[15:1] < 15'd100) ? mem[memRaddr[7:1]] : 16'h0000;

  always @(negedge clk) begin
    if (memRead) readCount++;
    if (memWrite) begin
      writeCount++;
      lastWaddr = memWaddr;
      lastWdata = memWdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: what a request should return and how it changes memory, from the access rules alone.
  function automatic void modelRequest(input logic write, input logic isByte, input logic sgn,
                                       input logic [15:0] addr, input logic [15:0] wdata,
                                       output int expLat, output logic [15:0] expData,
                                       output logic expErr, output int expReads, output int expWrites);
    int word, sh, v;
    word = int'(addr) / 2;
    sh   = (int'(addr) % 2) * 8;
    expErr = (word >= 100) || (!isByte && (int'(addr) % 2 == 1));
`ifndef MAU_BYTE_ACCESS_EN
    if (isByte) expErr = 1'b1;
`endif
    expData = 16'h0000;
    expReads = 0;
    expWrites = 0;
    if (expErr) begin
      expLat = 1;
    end else if (!write) begin
      expLat = 2;
      expReads = 1;
      v = int'(refMem[7'(word)]);
      if (isByte) begin
        v = (v >> sh) % 256;
        if (sgn && v >= 128) v = v + 'hFF00;
      end
      expData = 16'(v);
    end else begin
      expWrites = 1;
      if (!isByte) begin
        expLat = 2;
        refMem[7'(word)] = wdata;
      end else begin
        expLat = 3;
        expReads = 1;
        v = int'(refMem[7'(word)]);
        v = v - (((v >> sh) % 256) << sh) + ((int'(wdata) % 256) << sh);
        refMem[7'(word)] = 16'(v);
      end
    end
  endfunction

  task automatic applyStimulus(input string tag, input logic write, input logic isByte, input logic sgn,
                               input logic [15:0] addr, input logic [15:0] wdata);
    int expLat, expReads, expWrites, reads0, writes0, lat;
    logic [15:0] expData, gotData;
    logic expErr, gotErr;
    @(negedge clk);
    checkOutput({tag, ".ready"}, 32'(reqReady), 32'd1);
    reads0 = readCount;
    writes0 = writeCount;
    reqValid = 1'b1;
    reqWrite = write;
    reqByte = isByte;
    reqSigned = sgn;
    reqAddr = addr;
    reqWdata = wdata;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWrite = 1'($urandom_range(0, 1));
    reqByte = 1'($urandom_range(0, 1));
    reqAddr = 16'($urandom);
    reqWdata = 16'($urandom);
    modelRequest(write, isByte, sgn, addr, wdata, expLat, expData, expErr, expReads, expWrites);
    lat = 0;
    gotData = 16'h0000;
    gotErr = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (rspValid) begin
        lat = k;
        gotData = rspRdata;
        gotErr = rspErr;
      end
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".err"}, 32'(gotErr), 32'(expErr));
    checkOutput({tag, ".rdata"}, 32'(gotData), 32'(expData));
    @(negedge clk);
    checkOutput({tag, ".rspOnce"}, 32'(rspValid), 32'd0);
    checkOutput({tag, ".memReads"}, 32'(readCount - reads0), 32'(expReads));
    checkOutput({tag, ".memWrites"}, 32'(writeCount - writes0), 32'(expWrites));
    lastRdata = gotData;
    lastErr = gotErr;
    lastLat = lat;
  endtask

  // Request accepted, then reset pulsed inside the first busy cycle: nothing may be written or answered.
  task automatic abortStore(input string tag, input logic isByte, input logic [15:0] addr, input logic [15:0] wdata);
    int writes0, rspSeen;
    @(negedge clk);
    writes0 = writeCount;
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqByte = isByte;
    reqSigned = 1'b0;
    reqAddr = addr;
    reqWdata = wdata;
    @(posedge clk);
    #2;
    reqValid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput({tag, ".memWriteAsync"}, 32'(memWrite), 32'd0);
    checkOutput({tag, ".memReadAsync"}, 32'(memRead), 32'd0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rspSeen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rspValid) rspSeen++;
    end
    checkOutput({tag, ".noResponse"}, 32'(rspSeen), 32'd0);
    checkOutput({tag, ".readyAfter"}, 32'(reqReady), 32'd1);
    checkOutput({tag, ".noWrite"}, 32'(writeCount - writes0), 32'd0);
    checkOutput({tag, ".wordKept"}, 32'(mem[addr[7:1]]), 32'(refMem[addr[7:1]]));
  endtask

  initial begin
    int rWord, memMismatch;
    logic rWrite, rIsByte, rSgn, rOdd;
    reset = 1'b0;
    preload = 1'b1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqByte = 1'b0;
    reqSigned = 1'b0;
    reqAddr = '0;
    reqWdata = '0;
    for (int i = 0; i < 128; i++) begin
      initImage[i] = (i == 0) ? 16'h1BCD : 16'($urandom);
      refMem[i] = initImage[i];
    end
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    checkOutput("reset.ready", 32'(reqReady), 32'd1);
    checkOutput("reset.rspValid", 32'(rspValid), 32'd0);
    checkOutput("reset.rspErr", 32'(rspErr), 32'd0);
    checkOutput("reset.rspRdata", 32'(rspRdata), 32'd0);
    checkOutput("reset.memRead", 32'(memRead), 32'd0);
    checkOutput("reset.memWrite", 32'(memWrite), 32'd0);
    checkOutput("reset.memRaddr", 32'(memRaddr), 32'd0);
    checkOutput("reset.memWaddr", 32'(memWaddr), 32'd0);
    checkOutput("reset.memWdata", 32'(memWdata), 32'd0);
    reset = 1'b1;

    applyStimulus("hwLoad0", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("hwLoad0.const", 32'(lastRdata), 32'h1BCD);
    checkOutput("hwLoad0.constLat", 32'(lastLat), 32'd2);
`ifdef MAU_BYTE_ACCESS_EN
    applyStimulus("bLoadS0", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    checkOutput("bLoadS0.const", 32'(lastRdata), 32'hFFCD);
    applyStimulus("bLoadS1", 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000);
    checkOutput("bLoadS1.const", 32'(lastRdata), 32'h001B);
    applyStimulus("bLoadU0", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput("bLoadU0.const", 32'(lastRdata), 32'h00CD);
    applyStimulus("bStore1", 1'b1, 1'b1, 1'b0, 16'h0001, 16'h00A5);
    checkOutput("bStore1.waddr", 32'(lastWaddr), 32'h0000);
    checkOutput("bStore1.wdata", 32'(lastWdata), 32'hA5CD);
    applyStimulus("hwLoadBack", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("hwLoadBack.const", 32'(lastRdata), 32'hA5CD);
    applyStimulus("bLoadTop", 1'b0, 1'b1, 1'b1, 16'h00C7, 16'h0000);
    abortStore("abortRmw", 1'b1, 16'h0002, 16'h005A);
`else
    applyStimulus("bLoadOff", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    checkOutput("bLoadOff.constErr", 32'(lastErr), 32'd1);
    applyStimulus("hwStore4", 1'b1, 1'b0, 1'b0, 16'h0004, 16'h1234);
    applyStimulus("hwLoad4", 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0000);
    checkOutput("hwLoad4.const", 32'(lastRdata), 32'h1234);
`endif
    applyStimulus("misaligned", 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
    checkOutput("misaligned.constErr", 32'(lastErr), 32'd1);
    applyStimulus("outOfRange", 1'b1, 1'b0, 1'b0, 16'h00C8, 16'hBEEF);
    checkOutput("outOfRange.constErr", 32'(lastErr), 32'd1);
    applyStimulus("lastWord", 1'b1, 1'b0, 1'b0, 16'h00C6, 16'h7E57);
    applyStimulus("lastWordLd", 1'b0, 1'b0, 1'b0, 16'h00C6, 16'h0000);
    abortStore("abortStore", 1'b0, 16'h0006, 16'hDEAD);

    for (int n = 0; n < 60; n++) begin
      rWord = $urandom_range(0, 104);
      rWrite = 1'($urandom_range(0, 1));
      rIsByte = 1'($urandom_range(0, 1));
      rSgn = 1'($urandom_range(0, 1));
      rOdd = ($urandom_range(0, 5) == 0) || (rIsByte && $urandom_range(0, 1) == 1);
      applyStimulus("random", rWrite, rIsByte, rSgn, 16'(rWord * 2) | 16'(rOdd), 16'($urandom));
    end

    memMismatch = 0;
    for (int i = 0; i < 100; i++) begin
      if (mem[i] !== refMem[i]) memMismatch++;
    end
    checkOutput("finalMemImage", 32'(memMismatch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
